// File: rtl/req_tag_track_if.sv
// rtl/req_tag_track_if.sv - tag request, completion, drain and status signals of req_tag_track
interface req_tag_track_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = $clog2(WIDTH)
) ();
  logic             req_vld;
  logic             req_rdy;
  logic [TAG_W-1:0] req_tag;
  logic             cpl_vld;
  logic             cpl_last;
  logic [TAG_W-1:0] cpl_tag;
  logic             drain_req;
  logic             drain_done;
  logic [WIDTH-1:0] busy_vec;
  logic             busy_upd;
  logic             full;
  logic             empty;
  logic             err_dbl_free;
  logic             err_clr;

  modport master (
    output req_vld, cpl_vld, cpl_last, cpl_tag, drain_req, err_clr,
    input  req_rdy, req_tag, drain_done, busy_vec, busy_upd, full, empty, err_dbl_free
  );

  modport slave (
    input  req_vld, cpl_vld, cpl_last, cpl_tag, drain_req, err_clr,
    output req_rdy, req_tag, drain_done, busy_vec, busy_upd, full, empty, err_dbl_free
  );
endinterface

// File: rtl/req_tag_track.sv
// rtl/req_tag_track.sv - outstanding request tag allocator with drain and double-free detection
// Optional release-to-grant bypass: define REQ_TAG_TRACK_FREE_BYPASS_EN.
module req_tag_track #(
  parameter int WIDTH = 16,
  parameter int TAG_W = $clog2(WIDTH)
) (
  input logic            clk,
  input logic            rst,
  req_tag_track_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [WIDTH-1:0] r_busy;
  logic             r_upd;
  logic             r_done;
  logic             r_err;
  logic [0:0]       r_state;

  logic             w_full;
  logic             w_empty;
  logic             w_idle;
  logic [TAG_W-1:0] w_free_tag;
  logic             w_rel;
  logic             w_hit;
  logic             w_dbl;
  logic             w_rdy;
  logic [TAG_W-1:0] w_tag;
  logic             w_acc;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_next;
  logic [0:0]       w_state_nxt;
  logic             w_done_nxt;

  assign w_full  = &r_busy;
  assign w_empty = ~|r_busy;
  assign w_idle  = (r_state == S_IDLE);

  // Scan downward so the lowest free index is the last one written.
  always_comb begin
    w_free_tag = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_tag = TAG_W'(i);
    end
  end

  assign w_rel = bus.cpl_vld & bus.cpl_last;
  assign w_hit = r_busy[bus.cpl_tag];
  assign w_dbl = w_rel & ~w_hit;

`ifdef REQ_TAG_TRACK_FREE_BYPASS_EN
  logic w_byp;
  // A tag freed while full is handed straight back out in the same cycle.
  assign w_byp = w_full & w_idle & w_rel & w_hit;
  assign w_rdy = (~w_full & w_idle) | w_byp;
  assign w_tag = w_byp ? bus.cpl_tag : w_free_tag;
`else
  assign w_rdy = ~w_full & w_idle;
  assign w_tag = w_free_tag;
`endif

  assign w_acc  = bus.req_vld & w_rdy;
  assign w_set  = w_acc ? (WIDTH'(1) << w_tag) : '0;
  assign w_clr  = (w_rel & w_hit) ? (WIDTH'(1) << bus.cpl_tag) : '0;
  // Set after clear: a same-tag release and grant leaves the bit owned.
  assign w_next = (r_busy & ~w_clr) | w_set;

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.drain_req) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_empty) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (!bus.drain_req) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= '0;
      r_upd   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_state <= S_IDLE;
    end else begin
      r_busy  <= w_next;
      r_upd   <= (w_next != r_busy);
      r_done  <= w_done_nxt;
      r_state <= w_state_nxt;
      // A new error outranks a same-cycle clear.
      if (w_dbl)            r_err <= 1'b1;
      else if (bus.err_clr) r_err <= 1'b0;
    end
  end

  assign bus.req_rdy      = w_rdy;
  assign bus.req_tag      = w_tag;
  assign bus.busy_vec     = r_busy;
  assign bus.busy_upd     = r_upd;
  assign bus.drain_done   = r_done;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.err_dbl_free = r_err;

endmodule

// File: tb/tb_req_tag_track.sv
// tb/tb_req_tag_track.sv - directed self-checking bench for req_tag_track (WIDTH=16)
module tb_req_tag_track;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  req_tag_track_if #(.WIDTH(16), .TAG_W(4)) bus ();
  req_tag_track #(.WIDTH(16), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.req_vld   = 1'b0;
    bus.cpl_vld   = 1'b0;
    bus.cpl_last  = 1'b0;
    bus.cpl_tag   = 4'd0;
    bus.drain_req = 1'b0;
    bus.err_clr   = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic release_tag(input logic [3:0] t);
    bus.cpl_vld  = 1'b1;
    bus.cpl_last = 1'b1;
    bus.cpl_tag  = t;
  endtask

  task automatic cpl_off();
    bus.cpl_vld  = 1'b0;
    bus.cpl_last = 1'b0;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b1;
    #3;
    n_tests++; if (bus.busy_vec !== 16'h0000) begin n_fail++; $display("FAIL reset_busy_vec got %h want 0000", bus.busy_vec); end
    n_tests++; if (bus.busy_upd !== 1'b0) begin n_fail++; $display("FAIL reset_busy_upd got %b want 0", bus.busy_upd); end
    n_tests++; if (bus.drain_done !== 1'b0) begin n_fail++; $display("FAIL reset_drain_done got %b want 0", bus.drain_done); end
    n_tests++; if (bus.err_dbl_free !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.err_dbl_free); end
    n_tests++; if (bus.req_rdy !== 1'b1 || bus.req_tag !== 4'd0) begin n_fail++; $display("FAIL reset_req got rdy=%b tag=%0d want rdy=1 tag=0", bus.req_rdy, bus.req_tag); end
    n_tests++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_flags got empty=%b full=%b want 1 0", bus.empty, bus.full); end
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_alloc();
    int ups;
    logic [3:0] exp_tag [3];
    exp_tag[0] = 4'd0; exp_tag[1] = 4'd1; exp_tag[2] = 4'd2;
    ups = 0;
    do_reset();
    bus.req_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (bus.req_rdy !== 1'b1 || bus.req_tag !== exp_tag[i]) begin n_fail++; $display("FAIL alloc_grant%0d got rdy=%b tag=%0d want rdy=1 tag=%0d", i, bus.req_rdy, bus.req_tag, exp_tag[i]); end
      tick();
      if (bus.busy_upd === 1'b1) ups++;
    end
    bus.req_vld = 1'b0;
    tick();
    if (bus.busy_upd === 1'b1) ups++;
    n_tests++; if (bus.busy_vec !== 16'h0007) begin n_fail++; $display("FAIL alloc_busy_vec got %h want 0007", bus.busy_vec); end
    n_tests++; if (ups !== 3) begin n_fail++; $display("FAIL alloc_upd_count got %0d want 3", ups); end
  endtask

  task automatic test_release();
    release_tag(4'd1);
    tick();
    cpl_off();
    n_tests++; if (bus.busy_vec !== 16'h0005 || bus.busy_upd !== 1'b1) begin n_fail++; $display("FAIL release_vec got %h upd=%b want 0005 upd=1", bus.busy_vec, bus.busy_upd); end
    #1;
    n_tests++; if (bus.req_tag !== 4'd1) begin n_fail++; $display("FAIL release_next_tag got %0d want 1", bus.req_tag); end
    bus.req_vld = 1'b1;
    tick();
    bus.req_vld = 1'b0;
    n_tests++; if (bus.busy_vec !== 16'h0007) begin n_fail++; $display("FAIL regrant_vec got %h want 0007", bus.busy_vec); end
    bus.cpl_vld = 1'b1; bus.cpl_last = 1'b0; bus.cpl_tag = 4'd0;
    tick();
    cpl_off();
    n_tests++; if (bus.busy_vec !== 16'h0007 || bus.busy_upd !== 1'b0) begin n_fail++; $display("FAIL nonlast_beat got %h upd=%b want 0007 upd=0", bus.busy_vec, bus.busy_upd); end
    bus.req_vld = 1'b1;
    release_tag(4'd0);
    tick();
    bus.req_vld = 1'b0;
    cpl_off();
    n_tests++; if (bus.busy_vec !== 16'h000E || bus.busy_upd !== 1'b1) begin n_fail++; $display("FAIL simul_set_clr got %h upd=%b want 000e upd=1", bus.busy_vec, bus.busy_upd); end
  endtask

  task automatic test_full();
    do_reset();
    bus.req_vld = 1'b1;
    repeat (16) tick();
    n_tests++; if (bus.busy_vec !== 16'hFFFF || bus.full !== 1'b1 || bus.req_rdy !== 1'b0) begin n_fail++; $display("FAIL full_state got %h full=%b rdy=%b want ffff 1 0", bus.busy_vec, bus.full, bus.req_rdy); end
    release_tag(4'd9);
    #1;
`ifdef REQ_TAG_TRACK_FREE_BYPASS_EN
    n_tests++; if (bus.req_rdy !== 1'b1 || bus.req_tag !== 4'd9) begin n_fail++; $display("FAIL bypass_grant got rdy=%b tag=%0d want 1 9", bus.req_rdy, bus.req_tag); end
    tick();
    cpl_off();
    n_tests++; if (bus.busy_vec !== 16'hFFFF || bus.busy_upd !== 1'b0) begin n_fail++; $display("FAIL bypass_vec got %h upd=%b want ffff 0", bus.busy_vec, bus.busy_upd); end
`else
    n_tests++; if (bus.req_rdy !== 1'b0) begin n_fail++; $display("FAIL full_release_rdy got %b want 0", bus.req_rdy); end
    tick();
    cpl_off();
    n_tests++; if (bus.busy_vec !== 16'hFDFF || bus.busy_upd !== 1'b1) begin n_fail++; $display("FAIL full_release_vec got %h upd=%b want fdff 1", bus.busy_vec, bus.busy_upd); end
    #1;
    n_tests++; if (bus.req_rdy !== 1'b1 || bus.req_tag !== 4'd9) begin n_fail++; $display("FAIL full_regrant got rdy=%b tag=%0d want 1 9", bus.req_rdy, bus.req_tag); end
    tick();
    n_tests++; if (bus.busy_vec !== 16'hFFFF) begin n_fail++; $display("FAIL full_refill got %h want ffff", bus.busy_vec); end
`endif
    bus.req_vld = 1'b0;
  endtask

  task automatic test_dbl_free();
    do_reset();
    bus.req_vld = 1'b1;
    tick();
    bus.req_vld = 1'b0;
    release_tag(4'd5);
    tick();
    cpl_off();
    n_tests++; if (bus.err_dbl_free !== 1'b1 || bus.busy_vec !== 16'h0001) begin n_fail++; $display("FAIL dbl_free got err=%b vec=%h want 1 0001", bus.err_dbl_free, bus.busy_vec); end
    n_tests++; if (bus.busy_upd !== 1'b0) begin n_fail++; $display("FAIL dbl_free_upd got %b want 0", bus.busy_upd); end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_tests++; if (bus.err_dbl_free !== 1'b0) begin n_fail++; $display("FAIL err_clr got %b want 0", bus.err_dbl_free); end
    bus.err_clr = 1'b1;
    release_tag(4'd7);
    tick();
    cpl_off();
    bus.err_clr = 1'b0;
    n_tests++; if (bus.err_dbl_free !== 1'b1) begin n_fail++; $display("FAIL err_priority got %b want 1", bus.err_dbl_free); end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    bus.req_vld = 1'b1;
    release_tag(4'd1);
    tick();
    bus.req_vld = 1'b0;
    cpl_off();
    n_tests++; if (bus.busy_vec !== 16'h0003 || bus.err_dbl_free !== 1'b1) begin n_fail++; $display("FAIL same_tag got vec=%h err=%b want 0003 1", bus.busy_vec, bus.err_dbl_free); end
  endtask

  task automatic test_drain();
    int dones;
    dones = 0;
    do_reset();
    bus.req_vld = 1'b1;
    tick();
    tick();
    bus.req_vld = 1'b0;
    bus.drain_req = 1'b1;
    tick();
    n_tests++; if (bus.busy_vec !== 16'h0003 || bus.req_rdy !== 1'b0) begin n_fail++; $display("FAIL drain_block got vec=%h rdy=%b want 0003 0", bus.busy_vec, bus.req_rdy); end
    release_tag(4'd0);
    tick();
    if (bus.drain_done === 1'b1) dones++;
    release_tag(4'd1);
    tick();
    cpl_off();
    if (bus.drain_done === 1'b1) dones++;
    n_tests++; if (bus.empty !== 1'b1 || dones !== 0) begin n_fail++; $display("FAIL drain_empty got empty=%b dones=%0d want 1 0", bus.empty, dones); end
    tick();
    n_tests++; if (bus.drain_done !== 1'b1 || bus.req_rdy !== 1'b1) begin n_fail++; $display("FAIL drain_done got done=%b rdy=%b want 1 1", bus.drain_done, bus.req_rdy); end
    bus.drain_req = 1'b0;
    tick();
    n_tests++; if (bus.drain_done !== 1'b0) begin n_fail++; $display("FAIL drain_single_pulse got %b want 0", bus.drain_done); end
    bus.drain_req = 1'b1;
    tick();
    n_tests++; if (bus.drain_done !== 1'b0 || bus.req_rdy !== 1'b0) begin n_fail++; $display("FAIL drain_empty_enter got done=%b rdy=%b want 0 0", bus.drain_done, bus.req_rdy); end
    tick();
    bus.drain_req = 1'b0;
    n_tests++; if (bus.drain_done !== 1'b1) begin n_fail++; $display("FAIL drain_empty_done got %b want 1", bus.drain_done); end
    tick();
    bus.req_vld = 1'b1;
    tick();
    bus.req_vld = 1'b0;
    bus.drain_req = 1'b1;
    tick();
    bus.drain_req = 1'b0;
    tick();
    n_tests++; if (bus.drain_done !== 1'b0 || bus.req_rdy !== 1'b1 || bus.busy_vec !== 16'h0001) begin n_fail++; $display("FAIL drain_abort got done=%b rdy=%b vec=%h want 0 1 0001", bus.drain_done, bus.req_rdy, bus.busy_vec); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_vld = 1'b1;
    repeat (8) tick();
    bus.req_vld = 1'b0;
    for (int t = 0; t < 4; t++) begin
      release_tag(4'(t));
      tick();
    end
    cpl_off();
    bus.drain_req = 1'b1;
    tick();
    n_tests++; if (bus.busy_vec !== 16'h00F0 || bus.req_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_setup got vec=%h rdy=%b want 00f0 0", bus.busy_vec, bus.req_rdy); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (bus.busy_vec !== 16'h0000 || bus.busy_upd !== 1'b0 || bus.drain_done !== 1'b0 || bus.err_dbl_free !== 1'b0) begin n_fail++; $display("FAIL mid_reset_regs got vec=%h upd=%b done=%b err=%b want 0000 0 0 0", bus.busy_vec, bus.busy_upd, bus.drain_done, bus.err_dbl_free); end
    n_tests++; if (bus.req_rdy !== 1'b1 || bus.req_tag !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("FAIL mid_reset_comb got rdy=%b tag=%0d empty=%b full=%b want 1 0 1 0", bus.req_rdy, bus.req_tag, bus.empty, bus.full); end
    bus.drain_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_tests++; if (bus.busy_upd !== 1'b0 || bus.busy_vec !== 16'h0000 || bus.req_rdy !== 1'b1) begin n_fail++; $display("FAIL post_reset got upd=%b vec=%h rdy=%b want 0 0000 1", bus.busy_upd, bus.busy_vec, bus.req_rdy); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_release();
    test_full();
    test_dbl_free();
    test_drain();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
